// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - fetch/sequencing controller for the 9-bit accumulator core
//
// Owns the program counter and the two-cycle mode registers consumed by the
// control decoder. It runs the Start/Done handshake and keeps a saturating
// RUN-cycle counter with a watchdog that forces completion.
//
// Ports:
//   Clk, Reset_n          clock (rising edge), asynchronous active-low reset
//   Start                 start request level; a fall starts a run, a rise leaves DONE
//   Stall                 freeze PC/mode registers this cycle
//   Ack                   decoder "program done"
//   BranchEn/BranchTarget decoder absolute branch
//   NextState             decoder next mode (00 regular, 01 target, 10 immediate)
//   PrevInstructionIn     decoder instruction to remember
//   ProgCtr               instruction ROM address
//   CurrState             current mode, to decoder
//   PrevInstruction       previous-instruction register, to decoder
//   Run                   high only in RUN; gates architectural write enables
//   Done, Timeout         program finished / finish forced by the watchdog
//   CycleCount            RUN cycles elapsed (saturating)

module prog_sequencer #(
  parameter int unsigned         PC_W    = 9,
  parameter logic [PC_W-1:0]     INIT_PC = '0,
  parameter int unsigned         CNT_W   = 16,
  parameter int unsigned         TIMEOUT = 16'hFFFF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Ack,
  input  logic             BranchEn,
  input  logic [PC_W-1:0]  BranchTarget,
  input  logic [1:0]       NextState,
  input  logic [8:0]       PrevInstructionIn,
  output logic [PC_W-1:0]  ProgCtr,
  output logic [1:0]       CurrState,
  output logic [8:0]       PrevInstruction,
  output logic             Run,
  output logic             Done,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Count value seen in the last RUN cycle before the watchdog fires.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             start_q;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [1:0]       mode_q, mode_d;
  logic [8:0]       prev_q, prev_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      pc_q      <= INIT_PC;
      mode_q    <= 2'b00;
      prev_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= Start;
      pc_q      <= pc_d;
      mode_q    <= mode_d;
      prev_q    <= prev_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Saturating increment: all-ones holds rather than wrapping to zero.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mode_d    = mode_q;
    prev_d    = prev_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        // The start-fall branch also reloads, covering a one-cycle Start
        // pulse out of DONE where the high-level hold never ran in IDLE.
        if (Start || start_q) begin
          pc_d      = INIT_PC;
          mode_d    = 2'b00;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
        if (!Start && start_q) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (Start) begin
          state_d   = S_IDLE;
          pc_d      = INIT_PC;
          mode_d    = 2'b00;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (Ack) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            timeout_d = 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end else if (!Stall) begin
            pc_d   = BranchEn ? BranchTarget : pc_q + PC_W'(1);
            // Mode 11 is not a legal decoder output; fall back to regular.
            mode_d = (NextState == 2'b11) ? 2'b00 : NextState;
            prev_d = PrevInstructionIn;
          end
        end
      end

      S_DONE: begin
        // Only a fresh rising edge leaves DONE; a level already high is ignored.
        if (Start && !start_q) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ProgCtr         = pc_q;
  assign CurrState       = mode_q;
  assign PrevInstruction = prev_q;
  assign Run             = (state_q == S_RUN);
  assign Done            = done_q;
  assign Timeout         = timeout_q;
  assign CycleCount      = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - directed self-checking bench for prog_sequencer

module tb_prog_sequencer;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        Stall;
  logic        Ack;
  logic        BranchEn;
  logic [8:0]  BranchTarget;
  logic [1:0]  NextState;
  logic [8:0]  PrevInstructionIn;
  logic [8:0]  ProgCtr;
  logic [1:0]  CurrState;
  logic [8:0]  PrevInstruction;
  logic        Run;
  logic        Done;
  logic        Timeout;
  logic [15:0] CycleCount;

  int checks   = 0;
  int failures = 0;

  prog_sequencer #(
    .PC_W    (9),
    .INIT_PC (9'h000),
    .CNT_W   (16),
    .TIMEOUT (20)
  ) dut (
    .Clk               (Clk),
    .Reset_n           (Reset_n),
    .Start             (Start),
    .Stall             (Stall),
    .Ack               (Ack),
    .BranchEn          (BranchEn),
    .BranchTarget      (BranchTarget),
    .NextState         (NextState),
    .PrevInstructionIn (PrevInstructionIn),
    .ProgCtr           (ProgCtr),
    .CurrState         (CurrState),
    .PrevInstruction   (PrevInstruction),
    .Run               (Run),
    .Done              (Done),
    .Timeout           (Timeout),
    .CycleCount        (CycleCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int pc, input int cs, input int run,
                            input int done, input int to, input int cnt);
    check({tag, ".pc"},   32'(ProgCtr),    32'(pc));
    check({tag, ".cs"},   32'(CurrState),  32'(cs));
    check({tag, ".run"},  32'(Run),        32'(run));
    check({tag, ".done"}, 32'(Done),       32'(done));
    check({tag, ".to"},   32'(Timeout),    32'(to));
    check({tag, ".cnt"},  32'(CycleCount), 32'(cnt));
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    Reset_n           = 1'b0;
    Start             = 1'b0;
    Stall             = 1'b0;
    Ack               = 1'b0;
    BranchEn          = 1'b0;
    BranchTarget      = 9'h000;
    NextState         = 2'b00;
    PrevInstructionIn = 9'h000;
    #2;
    check_outs("rst", 0, 0, 0, 0, 0, 0);
    check("rst.prev", 32'(PrevInstruction), 32'h0);
    #20 Reset_n = 1'b1;

    // Start high for three cycles, then fall: RUN starts at INIT_PC.
    Start = 1'b1;
    repeat (3) tick();
    check_outs("idle", 0, 0, 0, 0, 0, 0);
    Start = 1'b0;
    PrevInstructionIn = 9'h0A5;
    tick();
    check_outs("run0", 0, 0, 1, 0, 0, 0);
    repeat (4) tick();
    check_outs("run4", 4, 0, 1, 0, 0, 4);
    check("run4.prev", 32'(PrevInstruction), 32'h0A5);

    // Mode change then branch.
    tick();
    NextState = 2'b01;
    tick();
    check_outs("mode1", 6, 1, 1, 0, 0, 6);
    BranchEn = 1'b1; BranchTarget = 9'h040; NextState = 2'b00;
    tick();
    check_outs("br40", 9'h040, 0, 1, 0, 0, 7);
    BranchTarget = 9'h007; PrevInstructionIn = 9'h123;
    tick();
    check_outs("br7", 7, 0, 1, 0, 0, 8);

    // Two stall cycles freeze PC/mode/prev while the counter runs.
    Stall = 1'b1; BranchEn = 1'b0; PrevInstructionIn = 9'h155; NextState = 2'b10;
    tick(); tick();
    check_outs("stall", 7, 0, 1, 0, 0, 10);
    check("stall.prev", 32'(PrevInstruction), 32'h123);
    Stall = 1'b0;
    tick();
    check_outs("unstall", 8, 2, 1, 0, 0, 11);
    check("unstall.prev", 32'(PrevInstruction), 32'h155);
    NextState = 2'b11;
    tick();
    check_outs("illegal", 9, 0, 1, 0, 0, 12);
    NextState = 2'b00;
    repeat (3) tick();
    check_outs("pc12", 12, 0, 1, 0, 0, 15);

    // Ack together with Stall: Ack wins.
    Ack = 1'b1; Stall = 1'b1;
    tick();
    check_outs("ack", 12, 0, 0, 1, 0, 16);
    Ack = 1'b0; Stall = 1'b0;
    tick();
    check_outs("done_hold", 12, 0, 0, 1, 0, 16);
    Start = 1'b1;
    tick();
    check_outs("restart", 12, 0, 0, 0, 0, 16);
    tick();
    check_outs("idle_hold", 0, 0, 0, 0, 0, 0);
    Start = 1'b0;
    tick();
    check_outs("run_b", 0, 0, 1, 0, 0, 0);
    tick(); tick();
    check_outs("run_b2", 2, 0, 1, 0, 0, 2);

    // Start high mid-RUN aborts to IDLE without Done.
    Start = 1'b1;
    tick();
    check_outs("abort", 0, 0, 0, 0, 0, 0);
    Start = 1'b0;
    tick();
    check_outs("run_c", 0, 0, 1, 0, 0, 0);

    // Watchdog: 20 RUN cycles with no Ack.
    repeat (19) tick();
    check_outs("pre_to", 19, 0, 1, 0, 0, 19);
    tick();
    check_outs("timeout", 19, 0, 0, 1, 1, 20);
    Start = 1'b1;
    tick();
    check_outs("to_leave", 19, 0, 0, 0, 1, 20);
    tick();
    check_outs("idle2", 0, 0, 0, 0, 0, 0);
    Start = 1'b0;
    tick();
    repeat (19) tick();
    check_outs("pre_ack20", 19, 0, 1, 0, 0, 19);
    Ack = 1'b1;
    tick();
    check_outs("ack20", 19, 0, 0, 1, 0, 20);
    Ack = 1'b0;

    // PC wrap from all-ones.
    Start = 1'b1;
    tick(); tick();
    Start = 1'b0;
    tick();
    check_outs("run_w", 0, 0, 1, 0, 0, 0);
    BranchEn = 1'b1; BranchTarget = 9'h1FF;
    tick();
    check_outs("pc1ff", 9'h1FF, 0, 1, 0, 0, 1);
    BranchEn = 1'b0;
    tick();
    check_outs("wrap", 0, 0, 1, 0, 0, 2);
    tick();

    // Asynchronous reset mid-RUN, observed before any clock edge.
    #2 Reset_n = 1'b0;
    #1;
    check_outs("async", 0, 0, 0, 0, 0, 0);
    check("async.prev", 32'(PrevInstruction), 32'h0);
    #1 Reset_n = 1'b1;
    repeat (3) tick();
    check_outs("stay_idle", 0, 0, 0, 0, 0, 0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    check_outs("run_d", 0, 0, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Fetch/sequencing controller for the 9-bit accumulator core.
- Owns the program counter and the two-cycle instruction-mode registers (CurrState, PrevInstruction) that the control decoder consumes.
- Applies the decoder's branch/next-state outputs each cycle and runs the Start/Done handshake with the testbench.
- Provides a saturating cycle counter and a watchdog timeout.

Parameters:
- PC_W, 9: program counter width; matches the BranchTarget width.
- INIT_PC, 0: PC value loaded on reset and on every program start.
- CNT_W, 16: CycleCount width.
- TIMEOUT, 16'hFFFF: RUN cycle count at which the sequencer force-finishes.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  testbench start request; level, see handshake.
- Stall  in  1  freeze PC/mode registers this cycle.
- Ack  in  1  decoder "program done" flag.
- BranchEn  in  1  decoder branch-taken.
- BranchTarget  in  PC_W  decoder absolute branch target.
- NextState  in  2  decoder next mode (00 regular, 01 target, 10 immediate).
- PrevInstructionIn  in  9  decoder instruction to remember.
- ProgCtr  out  PC_W  instruction ROM address.
- CurrState  out  2  current mode, to decoder.
- PrevInstruction  out  9  previous-instruction register, to decoder.
- Run  out  1  high only in RUN; gates all architectural write enables.
- Done  out  1  program finished; to testbench.
- Timeout  out  1  finish was forced by the watchdog.
- CycleCount  out  CNT_W  RUN cycles elapsed.

Behaviour:
- FSM states: IDLE, RUN, DONE. All outputs except Run are registered; Run is decoded from the FSM state.
- Reset (Reset_n low, asynchronous) sets:
  - FSM = IDLE
  - ProgCtr = INIT_PC
  - CurrState = 00, PrevInstruction = 0
  - Done = 0, Timeout = 0, CycleCount = 0
  - Run = 0
- Reset low mid-RUN aborts immediately to these values.
- Start handshake: a registered copy of Start (start_q) provides edge detection.
- IDLE:
  - While Start is high: hold ProgCtr = INIT_PC, CurrState = 00, CycleCount = 0, Timeout = 0.
  - On a falling edge of Start (start_q = 1, Start = 0): go to RUN. The first fetch is at INIT_PC, in the cycle after the edge.
  - Start held low from reset: stay in IDLE.
- RUN, per cycle, in priority order:
  1. Start = 1: abort to IDLE. ProgCtr = INIT_PC, CurrState = 00, Done stays 0.
  2. Ack = 1: go to DONE. No PC/mode update this cycle; ProgCtr stays on the done instruction. Timeout = 0.
  3. CycleCount == TIMEOUT - 1: go to DONE with Timeout = 1. No PC/mode update.
  4. Stall = 1: PC, CurrState and PrevInstruction hold. CycleCount still increments.
  5. Otherwise update:
     - ProgCtr <= BranchEn ? BranchTarget : ProgCtr + 1, with wrap modulo 2^PC_W (all-ones + 1 = 0).
     - CurrState <= NextState. NextState = 11 is illegal and is registered as 00.
     - PrevInstruction <= PrevInstructionIn.
- CycleCount in RUN: increments by 1 every RUN cycle, including the Ack/timeout cycle. Saturates at all-ones and never wraps.
- BranchEn is honoured in any CurrState. The decoder asserts it only in legal cases; the sequencer does not filter it.
- DONE:
  - Done = 1, Run = 0; ProgCtr, CycleCount and Timeout hold.
  - A rising edge of Start (Start = 1, start_q = 0) goes to IDLE with Done = 0 next cycle; the IDLE rules then apply.
  - Start already high on DONE entry does not restart; an edge is required.
- Simultaneous Ack and timeout: Ack wins, Timeout = 0.
- Simultaneous Ack and Stall: Ack wins.

Test Plan:
- Reset, then Start 1 for 3 cycles and 0 -> Run = 1 one cycle after the fall; ProgCtr steps 0, 1, 2, 3 on consecutive cycles; CurrState = 00; CycleCount = 4 after 4 RUN cycles.
- In RUN at ProgCtr = 5, NextState = 01 with BranchEn = 0, then next cycle BranchEn = 1 with BranchTarget = 9'h040 -> CurrState = 01 then 00; ProgCtr = 6 then 9'h040.
- Stall high for 2 cycles at ProgCtr = 7 -> ProgCtr stays 7, PrevInstruction unchanged, CycleCount +2; ProgCtr = 8 on the cycle after Stall drops.
- Ack at ProgCtr = 12 -> Done = 1 next cycle, Run = 0, ProgCtr = 12, Timeout = 0. A Start rising edge -> IDLE with Done = 0; after Start falls, a new run begins at ProgCtr = 0 with CycleCount = 0.
- TIMEOUT = 20, Ack never asserted -> Done = 1 and Timeout = 1 after exactly 20 RUN cycles. A separate case with Ack on the 20th cycle gives Timeout = 0.
- ProgCtr = 9'h1FF with no branch -> ProgCtr = 0. Reset_n pulsed low mid-RUN -> all outputs return to reset values asynchronously, and the sequencer stays in IDLE until the next Start fall.
